// File: rtl/systolic_ctrl_if.sv
// Host/array-facing bundle of the systolic controller: element write port, run control and skewed streams.
interface systolic_ctrl_if #(
  parameter int DW = 32
);
  logic          wr_en_i;
  logic          wr_sel_i;
  logic [3:0]    wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          wr_drop_o;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          arr_rst_no;
  logic [DW-1:0] left_o_0;
  logic [DW-1:0] left_o_1;
  logic [DW-1:0] left_o_2;
  logic [DW-1:0] left_o_3;
  logic [DW-1:0] up_o_0;
  logic [DW-1:0] up_o_1;
  logic [DW-1:0] up_o_2;
  logic [DW-1:0] up_o_3;

  modport master (
    output wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
    input  wr_drop_o, busy_o, done_o, arr_rst_no,
    input  left_o_0, left_o_1, left_o_2, left_o_3,
    input  up_o_0, up_o_1, up_o_2, up_o_3
  );

  modport slave (
    input  wr_en_i, wr_sel_i, wr_addr_i, wr_data_i, start_i,
    output wr_drop_o, busy_o, done_o, arr_rst_no,
    output left_o_0, left_o_1, left_o_2, left_o_3,
    output up_o_0, up_o_1, up_o_2, up_o_3
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for the 4x4 output-stationary systolic array: holds A/B, clears the array, feeds skewed streams.
// Run = CLEAR + 7 FEED beats + DRAIN + DONE, all outputs registered; writes/starts outside IDLE are dropped.
module systolic_ctrl #(
  parameter int DW    = 32,
  parameter int DRAIN = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  systolic_ctrl_if.slave bus
);
  localparam int N    = 4;
  localparam int CMAX = (DRAIN > 2*N-1) ? DRAIN : 2*N-1;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] FEED_LAST  = CW'(2*N-2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN-1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [DW-1:0] mat_a [16];
  logic [DW-1:0] mat_b [16];

  logic [2:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic [DW-1:0] left_nx [4];
  logic [DW-1:0] up_nx   [4];
  logic [DW-1:0] left_q  [4];
  logic [DW-1:0] up_q    [4];

  logic busy_q, done_q, arr_rst_n_q, wr_drop_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.start_i) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        state_nx = S_FEED;
        cnt_nx   = '0;
      end
      S_FEED: begin
        if (cnt == FEED_LAST) begin
          state_nx = S_DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Lane r carries A[r][j] / B[j][r] on beat r+j; outputs are registered from the next beat.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      left_nx[2'(r)] = '0;
      up_nx[2'(r)]   = '0;
    end
    if (state_nx == S_FEED) begin
      for (int r = 0; r < N; r++) begin
        for (int j = 0; j < N; j++) begin
          if (cnt_nx == CW'(r + j)) begin
            left_nx[2'(r)] = mat_a[4'(r*N + j)];
            up_nx[2'(r)]   = mat_b[4'(j*N + r)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) begin
        mat_a[4'(i)] <= '0;
        mat_b[4'(i)] <= '0;
      end
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= bus.wr_en_i && (state != S_IDLE);
      if (bus.wr_en_i && (state == S_IDLE)) begin
        if (bus.wr_sel_i) mat_b[bus.wr_addr_i] <= bus.wr_data_i;
        else              mat_a[bus.wr_addr_i] <= bus.wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arr_rst_n_q <= 1'b1;
      for (int r = 0; r < N; r++) begin
        left_q[2'(r)] <= '0;
        up_q[2'(r)]   <= '0;
      end
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      busy_q      <= (state_nx != S_IDLE);
      done_q      <= (state_nx == S_DONE);
      arr_rst_n_q <= (state_nx != S_CLEAR);
      left_q      <= left_nx;
      up_q        <= up_nx;
    end
  end

  assign bus.wr_drop_o  = wr_drop_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.arr_rst_no = arr_rst_n_q;
  assign bus.left_o_0   = left_q[0];
  assign bus.left_o_1   = left_q[1];
  assign bus.left_o_2   = left_q[2];
  assign bus.left_o_3   = left_q[3];
  assign bus.up_o_0     = up_q[0];
  assign bus.up_o_1     = up_q[1];
  assign bus.up_o_2     = up_q[2];
  assign bus.up_o_3     = up_q[3];
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: matrix model in plain arrays, expected streams from the skew rule per cycle.
module tb_systolic_ctrl;
  localparam int DW    = 32;
  localparam int DRAIN = 4;
  localparam int LAST  = 9 + DRAIN;   // cycle index of done_o after the start edge
  localparam int RUN   = LAST + 1;    // cycles per run including the idle sampling cycle

  typedef logic [8*DW+3:0] snap_t;    // {left0..3, up0..3, busy, done, arr_rst_n, wr_drop}

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [DW-1:0] ma [16];
  logic [DW-1:0] mb [16];
  snap_t         o_run [RUN+1];

  systolic_ctrl_if #(.DW(DW)) ifc ();
  systolic_ctrl #(.DW(DW), .DRAIN(DRAIN)) dut (.clk_i(clk), .rst_i(rst), .bus(ifc.slave));

  always #5 clk = ~clk;

  function automatic snap_t snap();
    return {ifc.left_o_0, ifc.left_o_1, ifc.left_o_2, ifc.left_o_3,
            ifc.up_o_0, ifc.up_o_1, ifc.up_o_2, ifc.up_o_3,
            ifc.busy_o, ifc.done_o, ifc.arr_rst_no, ifc.wr_drop_o};
  endfunction

  function automatic logic [DW-1:0] field(snap_t v, int idx);
    return v[4 + (7-idx)*DW +: DW];
  endfunction

  // Cycle n after the start edge: beats k = n-2 for n in 2..8.
  function automatic logic [DW-1:0] exp_left(int r, int n);
    int j;
    if (n < 2 || n > 8) return '0;
    j = n - 2 - r;
    if (j < 0 || j > 3) return '0;
    return ma[4'(r*4 + j)];
  endfunction

  function automatic logic [DW-1:0] exp_up(int c, int n);
    int j;
    if (n < 2 || n > 8) return '0;
    j = n - 2 - c;
    if (j < 0 || j > 3) return '0;
    return mb[4'(j*4 + c)];
  endfunction

  function automatic snap_t exp_vec(int n, int drop_n);
    return {exp_left(0, n), exp_left(1, n), exp_left(2, n), exp_left(3, n),
            exp_up(0, n), exp_up(1, n), exp_up(2, n), exp_up(3, n),
            (n <= LAST), (n == LAST), (n != 1), (n == drop_n)};
  endfunction

  task automatic host_write(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    ifc.wr_en_i   = 1'b1;
    ifc.wr_sel_i  = sel;
    ifc.wr_addr_i = addr;
    ifc.wr_data_i = data;
    @(negedge clk);
    ifc.wr_en_i   = 1'b0;
  endtask

  task automatic load(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    if (sel) mb[addr] = data;
    else     ma[addr] = data;
    host_write(sel, addr, data);
  endtask

  // Start a run and record RUN cycles; optional write during cycle wr_n (0 = with the start).
  task automatic run_capture(input int wr_n, input logic sel, input logic [3:0] addr,
                             input logic [DW-1:0] data);
    ifc.start_i   = 1'b1;
    ifc.wr_sel_i  = sel;
    ifc.wr_addr_i = addr;
    ifc.wr_data_i = data;
    ifc.wr_en_i   = (wr_n == 0);
    for (int n = 1; n <= RUN; n++) begin
      @(negedge clk);
      o_run[n]    = snap();
      ifc.start_i = 1'b0;
      ifc.wr_en_i = (n == wr_n);
    end
    ifc.wr_en_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.start_i = 1'b1;
    ifc.wr_en_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (snap() !== {{(8*DW){1'b0}}, 4'b0010}) begin
        tests_failed++;
        $display("FAIL reset_hold: got %h expected %h", snap(), {{(8*DW){1'b0}}, 4'b0010});
      end
    end
    rst = 1'b0;
    ifc.start_i = 1'b0;
    ifc.wr_en_i = 1'b0;
    @(negedge clk);
    tests_run++;
    if (snap() !== {{(8*DW){1'b0}}, 4'b0010}) begin
      tests_failed++;
      $display("FAIL reset_release: got %h expected %h", snap(), {{(8*DW){1'b0}}, 4'b0010});
    end
  endtask

  task automatic test_pattern();
    int k3 [8] = '{4, 7, 10, 13, 1, 2, 3, 4};
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        load(1'b0, 4'(i*4 + j), DW'(4*i + j + 1));
        load(1'b1, 4'(i*4 + j), DW'(j + 1));
      end
    end
    run_capture(-1, 1'b0, 4'h0, '0);
    for (int n = 1; n <= RUN; n++) begin
      tests_run++;
      if (o_run[n] !== exp_vec(n, -1)) begin
        tests_failed++;
        $display("FAIL pattern cycle %0d: got %h expected %h", n, o_run[n], exp_vec(n, -1));
      end
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (field(o_run[5], i) !== DW'(k3[i])) begin
        tests_failed++;
        $display("FAIL pattern_k3 stream %0d: got %0d expected %0d", i, field(o_run[5], i), k3[i]);
      end
    end
    tests_run++;
    if (field(o_run[2], 0) !== DW'(1) || field(o_run[2], 4) !== DW'(1)) begin
      tests_failed++;
      $display("FAIL pattern_k0: got left0=%0d up0=%0d expected 1 1", field(o_run[2], 0), field(o_run[2], 4));
    end
    tests_run++;
    if (field(o_run[8], 3) !== DW'(16) || field(o_run[8], 7) !== DW'(4)) begin
      tests_failed++;
      $display("FAIL pattern_k6: got left3=%0d up3=%0d expected 16 4", field(o_run[8], 3), field(o_run[8], 7));
    end
  endtask

  task automatic test_write_drop();
    int wn;
    run_capture(4, 1'b0, 4'h0, DW'(99));
    for (int n = 1; n <= RUN; n++) begin
      tests_run++;
      if (o_run[n] !== exp_vec(n, 5)) begin
        tests_failed++;
        $display("FAIL drop_fixed cycle %0d: got %h expected %h", n, o_run[n], exp_vec(n, 5));
      end
    end
    wn = $urandom_range(1, LAST);
    run_capture(wn, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), DW'($urandom));
    for (int n = 1; n <= RUN; n++) begin
      tests_run++;
      if (o_run[n] !== exp_vec(n, wn + 1)) begin
        tests_failed++;
        $display("FAIL drop_rand(w=%0d) cycle %0d: got %h expected %h", wn, n, o_run[n], exp_vec(n, wn + 1));
      end
    end
    tests_run++;
    if (field(o_run[2], 0) !== DW'(1)) begin
      tests_failed++;
      $display("FAIL drop_kept_a00: got %0d expected 1", field(o_run[2], 0));
    end
  endtask

  task automatic test_same_edge();
    mb[0] = DW'(7);
    run_capture(0, 1'b1, 4'h0, DW'(7));
    for (int n = 1; n <= RUN; n++) begin
      tests_run++;
      if (o_run[n] !== exp_vec(n, -1)) begin
        tests_failed++;
        $display("FAIL same_edge cycle %0d: got %h expected %h", n, o_run[n], exp_vec(n, -1));
      end
    end
    tests_run++;
    if (field(o_run[2], 4) !== DW'(7)) begin
      tests_failed++;
      $display("FAIL same_edge_up0: got %0d expected 7", field(o_run[2], 4));
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    int clears = 0;
    int waited = 0;
    ifc.start_i = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (ifc.done_o === 1'b1) pulses.push_back(c);
      if (ifc.arr_rst_no === 1'b0) clears++;
    end
    ifc.start_i = 1'b0;
    tests_run++;
    if (pulses.size() != 3) begin
      tests_failed++;
      $display("FAIL b2b_pulses: got %0d expected 3", pulses.size());
    end
    tests_run++;
    if (clears != 4) begin
      tests_failed++;
      $display("FAIL b2b_clears: got %0d expected 4", clears);
    end
    if (pulses.size() >= 3) begin
      tests_run++;
      if (pulses[0] != LAST) begin
        tests_failed++;
        $display("FAIL b2b_first: got %0d expected %0d", pulses[0], LAST);
      end
      for (int i = 1; i < 3; i++) begin
        tests_run++;
        if (pulses[i] - pulses[i-1] != RUN) begin
          tests_failed++;
          $display("FAIL b2b_spacing %0d: got %0d expected %0d", i, pulses[i] - pulses[i-1], RUN);
        end
      end
    end
    while (ifc.busy_o === 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (ifc.busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_idle_timeout: busy=%b expected 0", ifc.busy_o);
    end
  endtask

  task automatic test_mid_reset();
    int active = 0;
    ifc.start_i = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      ifc.start_i = 1'b0;
    end
    tests_run++;
    if (field(snap(), 0) !== exp_left(0, 5)) begin
      tests_failed++;
      $display("FAIL midrst_pre: got %0d expected %0d", field(snap(), 0), exp_left(0, 5));
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (snap() !== {{(8*DW){1'b0}}, 4'b0010}) begin
      tests_failed++;
      $display("FAIL midrst_now: got %h expected %h", snap(), {{(8*DW){1'b0}}, 4'b0010});
    end
    for (int i = 0; i < 16; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (ifc.done_o !== 1'b0 || ifc.busy_o !== 1'b0) active++;
    end
    tests_run++;
    if (active != 0) begin
      tests_failed++;
      $display("FAIL midrst_no_done: got %0d active cycles expected 0", active);
    end
    run_capture(-1, 1'b0, 4'h0, '0);
    for (int n = 1; n <= RUN; n++) begin
      tests_run++;
      if (o_run[n] !== exp_vec(n, -1)) begin
        tests_failed++;
        $display("FAIL midrst_zero_run cycle %0d: got %h expected %h", n, o_run[n], exp_vec(n, -1));
      end
    end
  endtask

  task automatic test_random();
    for (int rep = 0; rep < 4; rep++) begin
      int wn, dn;
      logic ws;
      logic [3:0] wa;
      logic [DW-1:0] wd;
      for (int i = 0; i < 24; i++) begin
        load(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), DW'($urandom));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      wn = int'($urandom_range(0, LAST + 1)) - 1;
      ws = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      wd = DW'($urandom);
      if (wn == 0) begin
        if (ws) mb[wa] = wd;
        else    ma[wa] = wd;
      end
      dn = (wn >= 1) ? wn + 1 : -1;
      run_capture(wn, ws, wa, wd);
      for (int n = 1; n <= RUN; n++) begin
        tests_run++;
        if (o_run[n] !== exp_vec(n, dn)) begin
          tests_failed++;
          $display("FAIL random rep %0d cycle %0d: got %h expected %h", rep, n, o_run[n], exp_vec(n, dn));
        end
      end
    end
  endtask

  initial begin
    ifc.wr_en_i   = 1'b0;
    ifc.wr_sel_i  = 1'b0;
    ifc.wr_addr_i = '0;
    ifc.wr_data_i = '0;
    ifc.start_i   = 1'b0;
    test_reset();
    test_pattern();
    test_write_drop();
    test_same_edge();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d comparisons made", tests_run);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencing controller for the 4x4 output-stationary systolic multiplier. It holds operand matrices A and B in local register files, loaded through a simple write port. On `start_i` it resets the array, then drives the diagonally skewed operand streams onto the array's four row (left) and four column (up) inputs. After the last operands have propagated it signals completion. It sits between the host/register interface and the array, and it replaces hand-skewed testbench stimulus.

## Interface
Parameters:
- `DW`, 32, operand width of every matrix element and array input.
- `DRAIN`, 4, idle cycles after the last feed beat before completion; must be ≥ 4 for N=4.

Array size N=4 is fixed.

Ports:
- `clk_i`  in  1  single clock, all logic on rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `wr_en_i`  in  1  matrix element write strobe.
- `wr_sel_i`  in  1  0 = matrix A, 1 = matrix B.
- `wr_addr_i`  in  4  element index, {row[1:0], col[1:0]}.
- `wr_data_i`  in  DW  element value.
- `wr_drop_o`  out  1  one-cycle pulse when a write was discarded because busy.
- `start_i`  in  1  begin a multiply (level sampled each edge).
- `busy_o`  out  1  high from CLEAR through DONE.
- `done_o`  out  1  one-cycle completion pulse.
- `arr_rst_no`  out  1  active-low synchronous reset to the array.
- `left_o_0` .. `left_o_3`  out  DW  row streams, to array `left_i_0/4/8/12`.
- `up_o_0` .. `up_o_3`  out  DW  column streams, to array `up_i_0..3`.

## Operation
FSM states and transitions:
- IDLE → CLEAR when `start_i` = 1.
- CLEAR (1 cycle) → FEED.
  - `arr_rst_no` = 0 for this single cycle only.
- FEED (2N-1 = 7 cycles, beat counter k = 0..6) → DRAIN.
- DRAIN (`DRAIN` cycles) → DONE.
- DONE (1 cycle) → IDLE.

Feed schedule, beat k:
- `left_o_r` = A[r][k-r] if 0 ≤ k-r ≤ 3, else 0.
- `up_o_c` = B[k-c][c] if 0 ≤ k-c ≤ 3, else 0.
- All stream outputs are 0 in every state other than FEED.

Writes:
- Accepted only in IDLE; element at (row, col) of the selected matrix is updated on the edge.
- Writes in any other state are discarded, and `wr_drop_o` pulses on the following cycle.

Start handling:
- `start_i` is ignored outside IDLE; no queuing.
- Write and start on the same IDLE edge: the write is committed and its value is used in the run.

Storage and arithmetic:
- Matrix storage persists across runs; only reset clears it.
- The controller does no arithmetic; values pass through unmodified at DW bits.

Reset, including mid-run:
- State → IDLE.
- All storage → 0.
- Outputs → 0, except `arr_rst_no` → 1.
- No `done_o` for the aborted run.

## Timing
- All outputs are registered; none is combinational from any input.
- With `start_i` sampled at edge E0:
  - CLEAR is the cycle after E0.
  - FEED beats k = 0..6 occupy cycles E0+2 .. E0+8.
  - DRAIN occupies E0+9 .. E0+8+`DRAIN`.
  - `done_o` is high for the single cycle E0+9+`DRAIN` (E0+13 at default).
- `busy_o` rises the cycle after E0 and falls after the DONE cycle.
- The earliest next start is the first edge at which the FSM is in IDLE; a run takes 3+2N-1+`DRAIN` cycles (14 at default).
- `wr_drop_o` is high exactly one cycle per discarded write.

## Test plan
1. Load A[i][j] = 4i+j+1 and B[i][j] = j+1, then start.
   - k=0: `left_o_0`=1, `up_o_0`=1, all other streams 0.
   - k=3: `left_o_0..3` = 4, 7, 10, 13; `up_o_0..3` = 1, 2, 3, 4.
   - k=6: only `left_o_3`=16 and `up_o_3`=4 are nonzero.
2. Same load, connected to the array. After `done_o`, the array holds C[i][j] = (j+1)·{10, 26, 42, 58}[i]. `done_o` is high exactly at E0+13; `arr_rst_no` is low only at E0+1.
3. Write A[0][0]=99 at E0+4 (busy).
   - `wr_drop_o` pulses at E0+5.
   - The next run shows `left_o_0`=1 at k=0.
4. Write B[0][0]=7 together with `start_i` in IDLE → `up_o_0`=7 at k=0.
5. Hold `start_i` high continuously → back-to-back runs with exactly 14-cycle spacing between `done_o` pulses; no start is captured while busy.
6. Assert `rst_i` at E0+5 (mid-FEED).
   - Immediately: all streams 0, `busy_o`=0, `arr_rst_no`=1.
   - No `done_o` for that run.
   - A subsequent start with no reload feeds all zeros.
